// File: rtl/state_dump_unit.sv
// state_dump_unit: freezes the core on halt or after a cycle budget, then
// streams PC followed by x0..x(NREGS-1) over a valid/ready channel.
module state_dump_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32,
  parameter int IDX_W = $clog2(NREGS+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          cycle_limit_i,
  input  logic                      halt_i,
  input  logic [XLEN-1:0]           pc_i,
  output logic                      freeze_o,
  output logic [$clog2(NREGS)-1:0]  rd_addr_o,
  input  logic [XLEN-1:0]           rd_data_i,
  output logic                      dump_valid_o,
  input  logic                      dump_ready_i,
  output logic [IDX_W-1:0]          dump_idx_o,
  output logic [XLEN-1:0]           dump_data_o,
  output logic                      dump_last_o,
  output logic                      done_o,
  output logic [CNT_W-1:0]          cycles_o
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {RUN, DUMP, DONE} st_t;

  st_t             st, st_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cycles;
  logic [XLEN-1:0]  pc_q;
  logic             trig, xfer, last_idx;

  // Limit compare uses the live limit; 0 disables the budget entirely.
  assign trig     = (st == RUN) &&
                    (halt_i || ((cycle_limit_i != '0) &&
                                (cycles == cycle_limit_i - CNT_W'(1))));
  assign last_idx = (idx == IDX_W'(NREGS));
  // Valid depends only on state, so ready never reaches valid combinationally.
  assign xfer     = (st == DUMP) && dump_ready_i;

  assign cycles_o   = cycles;
  assign dump_idx_o = idx;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= RUN;
    else     st <= st_nxt;
  end

  // Next-state: RUN until trigger, DUMP until the last beat transfers, DONE sticks.
  always_comb begin
    st_nxt = st;
    case (st)
      RUN:     if (trig) st_nxt = DUMP;
      DUMP:    if (xfer && last_idx) st_nxt = DONE;
      DONE:    st_nxt = DONE;
      default: st_nxt = RUN;
    endcase
  end

  // Datapath: saturating run counter, PC capture at trigger, beat index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles <= '0;
      pc_q   <= '0;
      idx    <= '0;
    end else begin
      if (st == RUN && cycles != '1) cycles <= cycles + CNT_W'(1);
      if (trig) begin
        pc_q <= pc_i;
        idx  <= '0;
      end else if (xfer && !last_idx) begin
        idx  <= idx + IDX_W'(1);
      end
    end
  end

  // Outputs decoded from the registered state; payload muxed by beat index.
  always_comb begin
    freeze_o     = (st != RUN);
    done_o       = (st == DONE);
    dump_valid_o = 1'b0;
    dump_last_o  = 1'b0;
    dump_data_o  = '0;
    rd_addr_o    = '0;
    if (st == DUMP) begin
      dump_valid_o = 1'b1;
      dump_last_o  = last_idx;
      if (idx != '0) rd_addr_o = AW'(idx - IDX_W'(1));
      if (idx == '0)               dump_data_o = pc_q;
      else if (idx == IDX_W'(1))   dump_data_o = '0;   // x0 is hardwired zero
      else                         dump_data_o = rd_data_i;
    end
  end
endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: a beat-list model plus directed scenarios.
module tb_state_dump_unit;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int CNT_W = 10;
  localparam int IDX_W = $clog2(NREGS+1);
  localparam int AW    = $clog2(NREGS);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 0, rst = 1, halt = 0, ready = 1;
  logic [CNT_W-1:0] lim = '0;
  logic [XLEN-1:0]  pc = 32'h100;
  logic             freeze, valid, last, done;
  logic [AW-1:0]    rd_addr;
  logic [XLEN-1:0]  rd_data, data;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cycles;

  logic [XLEN-1:0]  regs [NREGS];
  assign rd_data = regs[rd_addr];

  state_dump_unit #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cycle_limit_i(lim), .halt_i(halt), .pc_i(pc),
    .freeze_o(freeze), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .dump_valid_o(valid), .dump_ready_i(ready), .dump_idx_o(idx),
    .dump_data_o(data), .dump_last_o(last), .done_o(done), .cycles_o(cycles));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int xfers = 0, lasts = 0;
  int hits [NREGS+1];
  logic [XLEN-1:0] seen [NREGS+1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: before trigger just a saturating count; at trigger the whole
  // expected record is fixed and a pointer walks it on each accepted beat.
  bit              m_trig, m_done;
  int              m_ptr, m_cyc;
  logic [XLEN-1:0] m_beats [NREGS+1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_trig = 0; m_done = 0; m_ptr = 0; m_cyc = 0;
      for (int k = 0; k <= NREGS; k++) m_beats[k] = '0;
    end else if (!m_trig) begin
      bit t;
      t = halt || (lim != 0 && m_cyc == int'(lim) - 1);
      if (m_cyc != CMAX) m_cyc++;
      if (t) begin
        m_trig = 1; m_ptr = 0;
        m_beats[0] = pc;
        m_beats[1] = '0;
        for (int k = 2; k <= NREGS; k++) m_beats[k] = regs[k-1];
      end
    end else if (!m_done && ready) begin
      if (m_ptr == NREGS) m_done = 1;
      else m_ptr++;
    end
  end

  // Compare every cycle mid-low-phase; inputs and outputs are both settled.
  always @(negedge clk) begin
    bit ev;
    #2;
    ev = m_trig && !m_done;
    chk("freeze", freeze, m_trig);
    chk("valid", valid, ev);
    chk("done", done, m_done);
    chk("cycles", cycles, m_cyc);
    chk("idx", idx, m_ptr);
    chk("last", last, ev && m_ptr == NREGS);
    chk("data", data, ev ? m_beats[m_ptr] : '0);
    chk("rd_addr", rd_addr, (ev && m_ptr >= 1) ? m_ptr - 1 : 0);
    if (!rst && valid && ready) begin
      xfers++;
      if (int'(idx) <= NREGS) begin
        hits[idx]++;
        seen[idx] = data;
      end
      if (last) lasts++;
    end
  end

  // Inputs change just after the falling edge, well clear of the rising edge.
  task automatic step();
    @(negedge clk); #3;
    pc = pc + 4;
  endtask

  task automatic clr();
    xfers = 0; lasts = 0;
    for (int k = 0; k <= NREGS; k++) begin hits[k] = 0; seen[k] = '0; end
  endtask

  task automatic do_reset();
    rst = 1; halt = 0;
    repeat (3) step();
    clr();
    rst = 0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (!done && n < bound) begin step(); n++; end
    chk({name, "_done_timeout"}, done, 1);
  endtask

  task automatic chk_record(input string name);
    int bad = 0;
    for (int k = 0; k <= NREGS; k++) if (hits[k] != 1) bad++;
    chk({name, "_xfers"}, xfers, NREGS+1);
    chk({name, "_lasts"}, lasts, 1);
    chk({name, "_idx_hits"}, bad, 0);
  endtask

  initial begin
    int n;
    regs[0] = 32'hDEAD_BEEF;   // must never appear: x0 reads as zero
    for (int k = 1; k < NREGS; k++) regs[k] = k * 32'h11;
    clr();

    // Reset values and first counts.
    step();
    chk("rst_freeze", freeze, 0); chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);     chk("rst_done", done, 0);
    chk("rst_idx", idx, 0);       chk("rst_data", data, 0);
    chk("rst_rdaddr", rd_addr, 0); chk("rst_cycles", cycles, 0);
    step(); step();
    lim = 10; clr(); rst = 0;
    step(); chk("count1", cycles, 1);
    step(); chk("count2", cycles, 2);
    step(); chk("count3", cycles, 3);

    // Limit trigger with ready held high.
    n = 0;
    while (!freeze && n < 50) begin step(); n++; end
    chk("lim_freeze", freeze, 1);
    chk("lim_cycles", cycles, 10);
    n = 0;
    while (!done && n < 100) begin step(); n++; end
    chk("lim_done_latency", n, NREGS+1);
    chk("lim_x0", seen[1], 0);
    chk("lim_x1", seen[2], 32'h11);
    chk("lim_x31", seen[NREGS], 32'h20F);
    chk_record("lim");
    lim = 0; halt = 1; repeat (5) step(); halt = 0;
    chk("done_sticky", done, 1);

    // Backpressure 1,0,0,1.
    lim = 5; do_reset();
    n = 0;
    while (!done && n < 400) begin
      ready = (n % 4 == 0) || (n % 4 == 3);
      step(); n++;
    end
    ready = 1;
    chk("bp_done", done, 1);
    chk_record("bp");

    // Halt trigger at cycle 7.
    lim = 0; do_reset();
    n = 0;
    while (cycles != 6 && n < 50) begin step(); n++; end
    halt = 1; pc = 32'h40;
    step(); halt = 0;
    chk("halt_cycles", cycles, 7);
    wait_done("halt", 100);
    chk("halt_pc", seen[0], 32'h40);
    chk_record("halt");

    // No halt, no limit: never dumps; counter saturates.
    do_reset();
    repeat (1100) step();
    chk("nohalt_freeze", freeze, 0);
    chk("nohalt_xfers", xfers, 0);
    chk("nohalt_sat", cycles, CMAX);

    // Halt and limit on the same edge.
    lim = 8; do_reset();
    n = 0;
    while (cycles != 7 && n < 50) begin step(); n++; end
    halt = 1; step(); halt = 0;
    chk("both_cycles", cycles, 8);
    wait_done("both", 100);
    repeat (5) step();
    chk_record("both");

    // Asynchronous reset mid-dump, then a fresh run.
    lim = 4; do_reset();
    n = 0;
    while (!(valid && idx == 12) && n < 100) begin step(); n++; end
    chk("mid_reached12", idx, 12);
    rst = 1; #1;
    chk("mid_freeze", freeze, 0); chk("mid_valid", valid, 0);
    chk("mid_last", last, 0);     chk("mid_idx", idx, 0);
    chk("mid_data", data, 0);     chk("mid_cycles", cycles, 0);
    chk("mid_lasts", lasts, 0);
    do_reset();
    wait_done("mid", 100);
    chk("mid_cycles_final", cycles, 4);
    chk_record("mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
